// File: rtl/regfile_writeback_if.sv
// Result-writeback bus for regfile_writeback: offer handshake, two write ports,
// four read ports with hazard flags, and the pending-write status.
interface regfile_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  write;
  logic [3:0]  Y1;
  logic [3:0]  Y2;
  logic [31:0] v_Y1;
  logic [31:0] v_Y2;
  logic [3:0]  zero_reg;
  logic [3:0]  A;
  logic [3:0]  B;
  logic [3:0]  C;
  logic [3:0]  D;
  logic [31:0] v_A;
  logic [31:0] v_B;
  logic [31:0] v_C;
  logic [31:0] v_D;
  logic        hz_A;
  logic        hz_B;
  logic        hz_C;
  logic        hz_D;
  logic        empty;

  modport master (
    output in_valid, write, Y1, Y2, v_Y1, v_Y2, zero_reg, A, B, C, D,
    input  in_ready, v_A, v_B, v_C, v_D, hz_A, hz_B, hz_C, hz_D, empty
  );

  modport slave (
    input  in_valid, write, Y1, Y2, v_Y1, v_Y2, zero_reg, A, B, C, D,
    output in_ready, v_A, v_B, v_C, v_D, hz_A, hz_B, hz_C, hz_D, empty
  );
endinterface

// File: rtl/regfile_writeback.sv
// 16x32 register file fed through a 4-entry in-order write FIFO, one commit per cycle.
// Define WB_BYPASS_EN to forward pending FIFO data onto the read ports instead of flagging hazards.
module regfile_writeback (
  input  logic              clk,
  input  logic              reset,
  regfile_writeback_if.slave bus
);
  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } wb_entry_t;

  logic [31:0] regs_q [16];
  wb_entry_t   fifo_q [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;

  logic        accept;
  logic        en_y1;
  logic        en_y2;
  logic        drain;
  logic [1:0]  y2_slot;

  // Two free slots guarantee a full Y1+Y2 transaction always fits.
  assign bus.in_ready = !reset && (count_q <= 3'd2);
  assign bus.empty    = reset || (count_q == 3'd0);

  assign accept  = bus.in_valid && bus.in_ready;
  assign en_y1   = accept && bus.write[0] && (bus.Y1 != bus.zero_reg);
  assign en_y2   = accept && bus.write[1] && (bus.Y2 != bus.zero_reg);
  assign drain   = (count_q != 3'd0);
  assign y2_slot = wr_ptr_q + {1'b0, en_y1};

  always_comb begin
    wr_ptr_d = wr_ptr_q + 2'(en_y1) + 2'(en_y2);
    rd_ptr_d = rd_ptr_q + 2'(drain);
    count_d  = count_q + 3'(en_y1) + 3'(en_y2) - 3'(drain);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (drain) regs_q[fifo_q[rd_ptr_q].idx] <= fifo_q[rd_ptr_q].data;
    end
  end

  // NOTE: FIFO payload is not reset; count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (en_y1) fifo_q[wr_ptr_q] <= '{idx: bus.Y1, data: bus.v_Y1};
    if (en_y2) fifo_q[y2_slot]  <= '{idx: bus.Y2, data: bus.v_Y2};
  end

  logic [3:0]  rd_idx  [4];
  logic [31:0] rd_data [4];
  logic        rd_hz   [4];

  assign rd_idx[0] = bus.A;
  assign rd_idx[1] = bus.B;
  assign rd_idx[2] = bus.C;
  assign rd_idx[3] = bus.D;

  // NOTE: defaults precede every conditional write so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_data[p] = regs_q[rd_idx[p]];
      rd_hz[p]   = 1'b0;
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int k = 0; k < 4; k++) begin
        if ((3'(k) < count_q) && (fifo_q[rd_ptr_q + 2'(k)].idx == rd_idx[p])) begin
`ifdef WB_BYPASS_EN
          rd_data[p] = fifo_q[rd_ptr_q + 2'(k)].data;
`else
          rd_hz[p] = 1'b1;
`endif
        end
      end
      if (rd_idx[p] == bus.zero_reg) begin
        rd_data[p] = '0;
        rd_hz[p]   = 1'b0;
      end
    end
  end

  assign bus.v_A  = rd_data[0];
  assign bus.v_B  = rd_data[1];
  assign bus.v_C  = rd_data[2];
  assign bus.v_D  = rd_data[3];
  assign bus.hz_A = rd_hz[0];
  assign bus.hz_B = rd_hz[1];
  assign bus.hz_C = rd_hz[2];
  assign bus.hz_D = rd_hz[3];
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed steps plus a commit scoreboard
// that tracks every queued write and checks it on read port D as it commits.
module tb_regfile_writeback;
  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } ent_t;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_if bus ();

  regfile_writeback dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          total = 0;
  int          bad = 0;
  ent_t        exp_q[$];
  logic [31:0] model_regs [16];
  logic        chk_pending = 1'b0;
  logic [3:0]  chk_idx = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] x);
    logic [31:0] r;
    if (x == bus.zero_reg) return 32'h0;
    r = model_regs[x];
    if (BYPASS) foreach (exp_q[i]) if (exp_q[i].idx == x) r = exp_q[i].data;
    return r;
  endfunction

  function automatic logic exp_hz(input logic [3:0] x);
    if (BYPASS || x == bus.zero_reg) return 1'b0;
    foreach (exp_q[i]) if (exp_q[i].idx == x) return 1'b1;
    return 1'b0;
  endfunction

  // Scoreboard: checks status and the last commit, then advances to the next rising edge.
  always @(negedge clk) begin
    logic exp_rdy;
    ent_t h;
    ent_t e;
    exp_rdy = !reset && (exp_q.size() <= 2);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("empty", 32'(bus.empty), 32'(reset || exp_q.size() == 0));
    if (chk_pending) begin
      check("commit_v_D", bus.v_D, exp_read(chk_idx));
      check("commit_hz_D", 32'(bus.hz_D), 32'(exp_hz(chk_idx)));
    end
    chk_pending = 1'b0;
    if (reset) begin
      exp_q.delete();
      foreach (model_regs[i]) model_regs[i] = '0;
    end else begin
      if (exp_q.size() > 0) begin
        h = exp_q.pop_front();
        model_regs[h.idx] = h.data;
        chk_idx     = h.idx;
        chk_pending = 1'b1;
        bus.D       = h.idx;
      end
      if (exp_rdy && bus.in_valid) begin
        if (bus.write[0] && bus.Y1 != bus.zero_reg) begin
          e.idx = bus.Y1; e.data = bus.v_Y1; exp_q.push_back(e);
        end
        if (bus.write[1] && bus.Y2 != bus.zero_reg) begin
          e.idx = bus.Y2; e.data = bus.v_Y2; exp_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input bit use_model);
    logic [3:0] ia, ib, ic;
    for (int i = 0; i < 6; i++) begin
      ia = 4'(i); ib = 4'(i + 6); ic = 4'(i + 12);
      bus.A = ia; bus.B = ib; bus.C = ic;
      #1;
      check({tag, "_v_A"}, bus.v_A, use_model ? exp_read(ia) : 32'h0);
      check({tag, "_v_B"}, bus.v_B, use_model ? exp_read(ib) : 32'h0);
      check({tag, "_v_C"}, bus.v_C, use_model ? exp_read(ic) : 32'h0);
      check({tag, "_hz_C"}, 32'(bus.hz_C), 32'h0);
    end
  endtask

  task automatic offer(input logic [1:0] w, input logic [3:0] y1, input logic [31:0] d1,
                       input logic [3:0] y2, input logic [31:0] d2);
    bus.in_valid = 1'b1; bus.write = w;
    bus.Y1 = y1; bus.v_Y1 = d1; bus.Y2 = y2; bus.v_Y2 = d2;
  endtask

  initial begin
    int acc;
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.write = '0; bus.Y1 = '0; bus.Y2 = '0;
    bus.v_Y1 = '0; bus.v_Y2 = '0; bus.zero_reg = '0;
    bus.A = '0; bus.B = '0; bus.C = '0;
    tick(); tick();
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'h1);
    check_regs("post_rst", 1'b0);

    // Single write to register 3.
    tick();
    offer(2'b01, 4'd3, 32'hDEADBEEF, 4'd0, 32'h0);
    bus.A = 4'd3;
    tick();
    bus.in_valid = 1'b0; #1;
    check("single_hz_A", 32'(bus.hz_A), BYPASS ? 32'h0 : 32'h1);
    check("single_pend_v_A", bus.v_A, BYPASS ? 32'hDEADBEEF : 32'h0);
    check("single_pend_empty", 32'(bus.empty), 32'h0);
    tick(); #1;
    check("single_v_A", bus.v_A, 32'hDEADBEEF);
    check("single_done_hz", 32'(bus.hz_A), 32'h0);
    check("single_empty", 32'(bus.empty), 32'h1);

    // Y1 and Y2 to the same index: Y2 must win.
    offer(2'b11, 4'd5, 32'h1, 4'd5, 32'h2);
    bus.A = 4'd5;
    tick();
    bus.in_valid = 1'b0; #1;
    check("same_pend_v_A", bus.v_A, BYPASS ? 32'h2 : 32'h0);
    tick(); #1;
    check("same_mid_v_A", bus.v_A, BYPASS ? 32'h2 : 32'h1);
    check("same_mid_hz_A", 32'(bus.hz_A), BYPASS ? 32'h0 : 32'h1);
    tick(); #1;
    check("same_v_A", bus.v_A, 32'h2);
    check("same_empty", 32'(bus.empty), 32'h1);

    // Writes to zero_reg are dropped; reads of zero_reg return 0.
    bus.zero_reg = 4'd7;
    offer(2'b11, 4'd7, 32'hAAAA0007, 4'd8, 32'hBBBB0008);
    bus.A = 4'd7; bus.B = 4'd8;
    tick();
    bus.in_valid = 1'b0; #1;
    check("zero_pend_empty", 32'(bus.empty), 32'h0);
    check("zero_hz_A", 32'(bus.hz_A), 32'h0);
    tick(); #1;
    check("zero_one_entry", 32'(bus.empty), 32'h1);
    check("zero_v_B", bus.v_B, 32'hBBBB0008);
    check("zero_v_A", bus.v_A, 32'h0);
    bus.zero_reg = 4'd3; bus.C = 4'd3; #1;
    check("zero_forced_v_C", bus.v_C, 32'h0);
    bus.zero_reg = 4'd0;

    // Back-pressure: offer a full transaction every cycle.
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      offer(2'b11, 4'(1 + (2 * i) % 15), 32'hC000_0000 | 32'(2 * i),
            4'(1 + (2 * i + 1) % 15), 32'hC000_0000 | 32'(2 * i + 1));
      #1;
      acc += int'(bus.in_ready);
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd9);
    n = 0;
    #1;
    while (!bus.empty && n < 10) begin
      tick(); #1; n++;
    end
    check("bp_drained", 32'(bus.empty), 32'h1);
    check_regs("bp_final", 1'b1);

    // Reset with three writes pending; the reset-cycle offer is lost.
    tick();
    offer(2'b11, 4'd10, 32'h0A, 4'd11, 32'h0B);
    tick();
    offer(2'b11, 4'd12, 32'h0C, 4'd13, 32'h0D);
    tick(); #1;
    check("mid_rst_pending", 32'(bus.empty), 32'h0);
    reset = 1'b1;
    offer(2'b01, 4'd9, 32'h99, 4'd0, 32'h0);
    tick(); #1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'h0);
    reset = 1'b0; bus.in_valid = 1'b0;
    check_regs("mid_rst", 1'b0);
    tick(); #1;
    check("mid_rst_empty", 32'(bus.empty), 32'h1);
    check_regs("mid_rst_after", 1'b0);

    // Two pending writes to index 4.
    tick();
    offer(2'b11, 4'd4, 32'h11, 4'd4, 32'h22);
    bus.A = 4'd4;
    tick();
    bus.in_valid = 1'b0; #1;
    check("byp_v_A", bus.v_A, BYPASS ? 32'h22 : 32'h0);
    check("byp_hz_A", 32'(bus.hz_A), BYPASS ? 32'h0 : 32'h1);
    tick(); #1;
    check("byp_mid_v_A", bus.v_A, BYPASS ? 32'h22 : 32'h11);
    check("byp_mid_hz_A", 32'(bus.hz_A), BYPASS ? 32'h0 : 32'h1);
    tick(); #1;
    check("byp_final_v_A", bus.v_A, 32'h22);
    check("byp_final_empty", 32'(bus.empty), 32'h1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
